// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg: shared seven-segment patterns and settle default           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package seg7_pkg;

  localparam int DEFAULT_SETTLE = 16;

  // Active-low {dp,g,f,e,d,c,b,a}; bit 7 set keeps the decimal point dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_decode: BCD code to active-low segment pattern, with blanking   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      if (code <= 4'd9) begin
        pattern = SEG_DIGIT[code];
      end else begin
        pattern = SEG_DASH;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd3_seg7_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd3_seg7_display: settle-gated snapshot of three BCD digits driving |
// | three PWM-dimmed seven-segment displays.  Rev 1.0 - initial release  |
// +----------------------------------------------------------------------+
module bcd3_seg7_display
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] brightness,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic       updated
);

  localparam logic [15:0] SETTLE = 16'(SETTLE_CYCLES);

  logic [11:0] live;
  logic [11:0] d_q;
  logic [11:0] snap;
  logic [15:0] stab_cnt;
  logic [3:0]  pwm_cnt;
  logic        capture;
  logic        blank2;
  logic        blank1;
  logic        seg_on;
  logic [7:0]  pat0;
  logic [7:0]  pat1;
  logic [7:0]  pat2;

  assign live = {digit_3, digit_2, digit_1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q      <= '0;
      stab_cnt <= '0;
    end else begin
      d_q <= live;
      if (live != d_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != 16'hFFFF) begin
        stab_cnt <= stab_cnt + 16'd1;
      end
    end
  end

  // Saturation plus the snap comparison keeps a long-held value from re-firing.
  assign capture = (stab_cnt >= SETTLE) && (d_q != snap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap    <= '0;
      updated <= 1'b0;
    end else begin
      updated <= capture;
      if (capture) begin
        snap <= d_q;
      end
    end
  end

  // A dash code is non-zero, so it naturally stops the blanking chain.
  assign blank2 = BLANK_LEADING && (snap[11:8] == 4'd0);
  assign blank1 = blank2 && (snap[7:4] == 4'd0);

  seg7_decode u_dec0 (.code(snap[3:0]),  .blank(1'b0),   .pattern(pat0));
  seg7_decode u_dec1 (.code(snap[7:4]),  .blank(blank1), .pattern(pat1));
  seg7_decode u_dec2 (.code(snap[11:8]), .blank(blank2), .pattern(pat2));

  assign seg_on = (pwm_cnt < brightness) || (brightness == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      hex0    <= SEG_BLANK;
      hex1    <= SEG_BLANK;
      hex2    <= SEG_BLANK;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      hex0    <= seg_on ? pat0 : SEG_BLANK;
      hex1    <= seg_on ? pat1 : SEG_BLANK;
      hex2    <= seg_on ? pat2 : SEG_BLANK;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd3_seg7_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd3_seg7_display: scoreboard bench for bcd3_seg7_display         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_bcd3_seg7_display;

  localparam int S = 16;

  typedef struct {
    int          edge_no;
    logic [23:0] hex;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] digit_1 = 4'd0, digit_2 = 4'd0, digit_3 = 4'd0;
  logic [3:0] brightness = 4'hF;
  logic [7:0] hex0, hex1, hex2;
  logic       updated;
  logic [7:0] hex0_nb, hex1_nb, hex2_nb;
  logic       updated_nb;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   npulse = 0;
  int   expcount = 0;
  exp_t q[$];

  bcd3_seg7_display #(.SETTLE_CYCLES(S), .BLANK_LEADING(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .brightness(brightness),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .updated(updated)
  );

  bcd3_seg7_display #(.SETTLE_CYCLES(S), .BLANK_LEADING(1'b0)) u_nb (
    .clk(clk), .reset_n(reset_n),
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .brightness(brightness),
    .hex0(hex0_nb), .hex1(hex1_nb), .hex2(hex2_nb), .updated(updated_nb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every updated pulse must match the next queued snapshot.
  always @(negedge clk) begin
    if (reset_n && updated) begin
      npulse++;
      if (q.size() == 0) begin
        check("spurious_updated", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("updated_edge", cyc, e.edge_no);
        @(negedge clk);
        check("display", {hex2, hex1, hex0}, e.hex);
      end
    end
  end

  task automatic apply(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                       input logic [23:0] exp_hex, input bit cap);
    @(negedge clk);
    digit_3 = d3; digit_2 = d2; digit_1 = d1;
    if (cap) begin
      q.push_back('{cyc + S + 2, exp_hex});
      expcount++;
    end
    repeat (S + 6) @(negedge clk);
    check("pulse_count", npulse, expcount);
  endtask

  task automatic count_on(input logic [3:0] b, input int exp_on);
    int n;
    n = 0;
    @(negedge clk);
    brightness = b;
    repeat (32) begin
      @(negedge clk);
      if (hex0 != 8'hFF) n++;
    end
    check("pwm_on_count", n, exp_on);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    digit_1 = 4'(($urandom));
    digit_2 = 4'(($urandom));
    digit_3 = 4'(($urandom));
    repeat (4) @(negedge clk);
    check("reset_hex", {hex2, hex1, hex0}, 24'hFFFFFF);
    check("reset_updated", updated, 1'b0);
    digit_1 = 4'd0; digit_2 = 4'd0; digit_3 = 4'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_edge_hex", {hex2, hex1, hex0}, 24'hFFFFC0);
    check("first_edge_nb", {hex2_nb, hex1_nb, hex0_nb}, 24'hC0C0C0);

    apply(4'd1, 4'd2, 4'd3, 24'hF9A4B0, 1'b1);
    apply(4'd1, 4'd2, 4'd3, 24'h0, 1'b0);

    // Tearing: three separate writes, each inside the settle window.
    @(negedge clk);
    digit_1 = 4'd4;
    repeat (S - 2) @(negedge clk);
    digit_2 = 4'd5;
    repeat (S - 2) @(negedge clk);
    digit_3 = 4'd6;
    q.push_back('{cyc + S + 2, 24'h829299});
    expcount++;
    repeat (S + 6) @(negedge clk);
    check("tear_pulse_count", npulse, expcount);

    apply(4'd0, 4'd0, 4'd7, 24'hFFFFF8, 1'b1);
    check("noblank_007", {hex2_nb, hex1_nb, hex0_nb}, 24'hC0C0F8);
    apply(4'd0, 4'd5, 4'd0, 24'hFF92C0, 1'b1);
    apply(4'd2, 4'd0, 4'd0, 24'hA4C0C0, 1'b1);
    apply(4'hA, 4'd0, 4'd0, 24'hBFC0C0, 1'b1);
    apply(4'd0, 4'hB, 4'd0, 24'hFFBFC0, 1'b1);
    apply(4'd0, 4'd0, 4'hF, 24'hFFFFBF, 1'b1);
    apply(4'd0, 4'd0, 4'd0, 24'hFFFFC0, 1'b1);
    apply(4'd9, 4'd8, 4'd7, 24'h9080F8, 1'b1);

    count_on(4'd0, 0);
    count_on(4'd8, 16);
    count_on(4'd3, 6);
    count_on(4'hF, 32);

    // Reset three cycles into a settle window, away from any clock edge.
    @(negedge clk);
    digit_3 = 4'd1; digit_2 = 4'd1; digit_1 = 4'd1;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_hex", {hex2, hex1, hex0}, 24'hFFFFFF);
    check("midreset_updated", updated, 1'b0);
    digit_3 = 4'd0; digit_2 = 4'd0; digit_1 = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * S) @(negedge clk);
    check("post_reset_pulses", npulse, expcount);
    check("post_reset_hex", {hex2, hex1, hex0}, 24'hFFFFC0);

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
